seg_scan_reader: RTL and testbench
==================================

Name: seg_scan_reader

Overview:
- Read side of the 32-bit, 8-nibble digit store written by the switch-driven nibble writer.
- Snapshots the store once per frame and time-multiplexes the 8 nibbles onto an 8-digit common-anode 7-segment display as hex.
- Optional leading-zero blanking.
- Optional blinking cursor on the digit currently selected for writing.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= 2.
- BLINK_FRAMES, 64: full frames per cursor blink-phase toggle; legal range >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- numStorage  in  32  digit store; nibble k = numStorage[4k+3:4k] = display digit k (digit 0 rightmost)
- cursorSel  in  3  index of digit being edited (same encoding as the writer's bit select)
- cursorEn  in  1  1 = cursor blink and decimal point enabled
- blankEn  in  1  1 = leading-zero blanking enabled
- an  out  8  anode enables, active-low; an[k] drives digit k
- seg  out  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a
- dp  out  1  decimal point, active-low
- frameStart  out  1  one-cycle pulse on the cycle the snapshot loads

Behaviour:
- Reset (async assert, sync release) values:
  - an = 8'hFF, seg = 7'h7F, dp = 1, frameStart = 0.
  - Prescaler = 0, idx = 0, snap = 0, primed = 0, frame counter = 0, blink phase = 0.
- Prime: on the first clk edge with rst_n high and primed = 0:
  - snap <= numStorage, primed <= 1, frameStart = 1 for that cycle.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. A "tick" is the edge where prescaler == REFRESH_DIV-1.
- On tick:
  - idx <= idx+1, wrapping 7 -> 0.
  - If idx was 7 (frame boundary): snap <= numStorage, frameStart pulses, frame counter increments.
  - When the frame counter reaches BLINK_FRAMES-1 and wraps to 0, blink phase toggles.
- numStorage is sampled only at the prime and frame boundaries. Mid-frame changes do not appear until the next frame, which prevents tearing.
- Output register: updated every cycle from the current idx and snap, so outputs lag idx by exactly 1 cycle.
  - an: all ones except bit idx = 0, unless the digit is blanked (then an = 8'hFF).
  - seg = hex_to_seg(snap nibble idx).
  - dp = 0 iff cursorEn and idx == cursorSel, else 1.
- Blank conditions, either one blanks the digit:
  - Leading zero: blankEn = 1, idx != 0, and snap nibbles idx..7 are all zero. Digit 0 is never blanked by this rule.
  - Cursor: cursorEn = 1, idx == cursorSel, and blink phase = 1. This also forces dp = 1.
- Decode, hex digit to seg value (active-low gfedcba):
  - 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E
- Latency: a numStorage write is visible within at most 8*REFRESH_DIV+1 cycles.
- cursorSel, cursorEn and blankEn are not snapshotted. They take effect on the next output register update.
- Reset mid-frame: outputs blank immediately (async). After release, operation restarts with the prime on the first edge and scanning from digit 0.

Decomposition:
- Package seg_scan_pkg:
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 8'hFF.
  - 16-entry hex-to-segment constant table.
  - Digit-index type (3 bits).
- Sub-module hex_to_seg: combinational 4-bit -> 7-bit active-low decoder using the package table.
- Top contains: prescaler, idx counter, snapshot/prime logic, frame and blink counters, blank logic, output register.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset check: hold rst_n=0 -> an=FF, seg=7F, dp=1. Release with numStorage=32'h76543210 -> frameStart on 1st edge; first slot an=FE, seg=40; every 4 cycles an walks FD,FB,...,7F with seg 79,24,30,19,12,02,78; wraps to FE.
- Anti-tearing: mid-frame at idx=3, change numStorage to 32'hFFFFFFFF -> digits 4..7 still show 4..7. Next frame all digits show seg=0E, with frameStart coincident with the reload.
- Leading-zero blanking: blankEn=1, numStorage=32'h00000A05 -> digits 0..2 lit (12,40,08), digits 3..7 an=FF. With numStorage=0, only digit 0 is lit (seg=40).
- Cursor: cursorEn=1, cursorSel=5 -> dp=0 only in digit-5 slot. Blink phase toggles every 2 frames: digit 5 dark (an=FF, dp=1) in frames 2-3, lit in frames 4-5.
- Async reset mid-scan: pull rst_n low between edges at idx=6 -> an=FF, seg=7F immediately. After release, scanning restarts at digit 0 with a new snapshot.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared constants and types for the 7-segment scan reader.
//   SEG_BLANK      : all segments off (active-low)
//   AN_OFF         : all anodes off (active-low)
//   HEX_SEG_TABLE  : hex digit -> active-low gfedcba pattern, entry [n] is digit n
//   digit_idx_t    : index of one of the 8 display digits
package seg_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Packed so that the rightmost entry is digit 0 and the leftmost is digit F.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_reader_hex_to_seg.sv
// hex_to_seg
// Combinational hex digit to 7-segment decoder (active-low segments).
//   hex : 4-bit digit value
//   seg : segment pattern, seg[6:0] = g,f,e,d,c,b,a, 0 = segment lit
module hex_to_seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader
// Read side of the 8-nibble digit store. Takes a snapshot of the store once
// per frame and scans the 8 nibbles onto a common-anode 7-segment display as
// hex, with optional leading-zero blanking and a blinking edit cursor.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   numStorage : digit store, nibble k is display digit k (digit 0 rightmost)
//   cursorSel  : digit currently being edited
//   cursorEn   : enables cursor blink and decimal point
//   blankEn    : enables leading-zero blanking
//   an         : anode enables, active-low, an[k] drives digit k
//   seg        : segments, active-low, g..a
//   dp         : decimal point, active-low
//   frameStart : one-cycle pulse on the cycle the snapshot loads
module seg_scan_reader
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] numStorage,
    input  logic [2:0]  cursorSel,
    input  logic        cursorEn,
    input  logic        blankEn,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frameStart
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    logic [31:0]   snap;
    logic          primed;
    logic [FW-1:0] frame_cnt;
    logic          blink;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic          lead_zero;
    logic          cursor_hit;
    logic          cursor_blank;

    assign tick      = (presc == PW'(REFRESH_DIV - 1));
    assign frame_end = tick && (idx == 3'd7);

    // Prescaler and digit slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // The store is only sampled at the prime and at frame boundaries, so a
    // write landing mid-frame can never tear a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            primed     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= !primed || frame_end;
            if (!primed) begin
                snap   <= numStorage;
                primed <= 1'b1;
            end else if (frame_end) begin
                snap   <= numStorage;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign nibble = snap[{idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (seg_dec)
    );

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always stays lit so a zero value still shows "0".
    assign lead_zero    = blankEn && (idx != 3'd0) && ((snap >> {idx, 2'b00}) == 32'd0);
    assign cursor_hit   = cursorEn && (idx == cursorSel);
    assign cursor_blank = cursor_hit && blink;

    // Output register, refreshed every cycle from the current slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= (lead_zero || cursor_blank) ? AN_OFF : ~(8'd1 << idx);
            seg <= seg_dec;
            dp  <= !(cursor_hit && !cursor_blank);
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
// Scoreboard bench for seg_scan_reader with REFRESH_DIV=4, BLINK_FRAMES=2.
// The driver pushes the expected display state for every clock edge into a
// queue; a separate monitor pops and compares just after each edge.
module tb_seg_scan_reader;

    localparam int R  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] numStorage = 32'd0;
    logic [2:0]  cursorSel = 3'd0;
    logic        cursorEn = 1'b0;
    logic        blankEn = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frameStart;

    typedef struct packed {
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        logic [31:0] edge_no;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hist[$];
    int          edges = 0;
    int          errors = 0;
    int          checks = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_reader #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .numStorage (numStorage),
        .cursorSel  (cursorSel),
        .cursorEn   (cursorEn),
        .blankEn    (blankEn),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    // Expected display right after edge e (counted from reset release).
    // The display reflects the scan position reached after e-1 edges: one
    // digit slot every R edges, eight slots per frame, and the frame's
    // content is whatever the store held at the edge that opened the frame.
    function automatic exp_t model(input int e);
        exp_t        r;
        int          m;
        int          slot;
        int          frame;
        int          idx;
        logic [31:0] shown;
        logic [31:0] upper;
        bit          blink;
        bit          hit;
        bit          dark;
        m     = e - 1;
        slot  = m / R;
        idx   = slot % 8;
        frame = slot / 8;
        if (m == 0)          shown = 32'd0;
        else if (frame == 0) shown = hist[0];
        else                 shown = hist[8 * R * frame - 1];
        blink = ((frame / BF) % 2) == 1;
        upper = shown >> (4 * idx);
        hit   = cursorEn && (int'(cursorSel) == idx);
        dark  = (blankEn && idx != 0 && upper == 32'd0) || (hit && blink);
        r.an      = dark ? 8'hFF : ~(8'd1 << idx);
        r.seg     = hex_tab[upper[3:0]];
        r.dp      = (hit && !blink) ? 1'b0 : 1'b1;
        r.fs      = (e == 1) || (e % (8 * R) == 0);
        r.edge_no = e;
        return r;
    endfunction

    task automatic checkOutput(input string name, input exp_t ex);
        checks++;
        if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || frameStart !== ex.fs) begin
            errors++;
            $display("[TB] FAIL %s edge=%0d got an=%h seg=%h dp=%b fs=%b expected an=%h seg=%h dp=%b fs=%b",
                     name, ex.edge_no, an, seg, dp, frameStart, ex.an, ex.seg, ex.dp, ex.fs);
        end
    endtask

    // Drives inputs for n edges and records the expected result of each.
    task automatic applyStimulus(input logic [31:0] ns, input logic [2:0] sel,
                                 input logic cen, input logic ben, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            numStorage = ns;
            cursorSel  = sel;
            cursorEn   = cen;
            blankEn    = ben;
            edges++;
            hist.push_back(numStorage);
            exp_q.push_back(model(edges));
        end
    endtask

    task automatic checkResetState(input string name);
        exp_t ex;
        ex.an = 8'hFF; ex.seg = 7'h7F; ex.dp = 1'b1; ex.fs = 1'b0; ex.edge_no = 0;
        checkOutput(name, ex);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic randomBurst(input int n);
        logic [31:0] r;
        int          sh;
        logic [31:0] ns;
        r  = $urandom;
        sh = $urandom_range(0, 8);
        ns = (sh == 8) ? 32'd0 : (r >> (4 * sh));
        applyStimulus(ns, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), n);
    endtask

    // Monitor: one expected entry exists for every active edge.
    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t ex;
            #1;
            ex = exp_q.pop_front();
            checkOutput("scan", ex);
        end
    end

    initial begin
        numStorage = 32'h76543210;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset_hold");
        releaseReset();

        // Plain scan, then a store change in the middle of frame 1.
        applyStimulus(32'h76543210, 3'd0, 1'b0, 1'b0, 45);
        applyStimulus(32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 40);

        // Leading-zero blanking.
        applyStimulus(32'h00000A05, 3'd0, 1'b0, 1'b1, 70);
        applyStimulus(32'h00000000, 3'd0, 1'b0, 1'b1, 70);

        // Random traffic.
        for (int i = 0; i < 50; i++) randomBurst($urandom_range(5, 40));

        // Land on digit slot 6, then reset between edges.
        while ((edges % (8 * R)) != 6 * R) randomBurst(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        edges = 0;
        hist.delete();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset_hold2");
        releaseReset();

        // Cursor on digit 5 across six frames so both blink phases appear.
        applyStimulus(32'h89ABCDEF, 3'd5, 1'b1, 1'b0, 6 * 8 * R + 8);

        for (int i = 0; i < 20; i++) randomBurst($urandom_range(5, 40));

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
